cmd_uart_responder: RTL and testbench
=====================================

# cmd_uart_responder

Responder end of the Bluetooth command link inside the KnightsTour top level. Receives 16-bit commands from the remote initiator as two 8N1 UART bytes (high byte first), assembles them, and presents a command with a ready flag to the command processor. Transmits 8-bit status responses back over the same link.

## Interface
- BAUD_DIV, 5208 — clocks per bit (50 MHz / 9600 baud); legal range 16..65535
- PAIR_TIMEOUT, 40 — bit times allowed between high-byte stop bit and low-byte start bit before the assembler resynchronises
- clk  in  1  system clock; one clock
- rst  in  1  reset, synchronous, active-high
- RX  in  1  serial input from the initiator; asynchronous, idles high
- TX  out  1  serial output to the initiator; idles high
- cmd  out  16  assembled command, {high byte, low byte}
- cmd_rdy  out  1  a new command is held in cmd
- clr_cmd_rdy  in  1  consumer acknowledge; clears cmd_rdy
- resp  in  8  response byte to send
- send_resp  in  1  single-cycle strobe: start transmitting resp
- resp_sent  out  1  last response fully transmitted; sticky until the next send_resp
- tx_busy  out  1  transmitter is sending a frame

## Operation
- RX passes through a 2-flop synchroniser; the start bit is the falling edge of the synchronised signal.
- Receiver FSM: IDLE -> START (wait BAUD_DIV/2, re-check for low; if high, false start -> IDLE) -> DATA (8 bits LSB first, sampled at mid-bit, BAUD_DIV apart) -> STOP (sample at mid-bit) -> IDLE.
- Stop bit sampled low: framing error; discard the byte and return the assembler to WAIT_HIGH.
- Assembler FSM: WAIT_HIGH -> (good byte) latch the high byte, go to WAIT_LOW -> (good byte) load cmd = {high, low}, set cmd_rdy, go to WAIT_HIGH.
- WAIT_LOW timeout: counter runs from the high-byte stop sample and is cleared when a start bit is detected. At PAIR_TIMEOUT×BAUD_DIV clocks, discard the high byte and return to WAIT_HIGH.
- cmd_rdy clears on clr_cmd_rdy, or when a high byte completes, whichever comes first.
- cmd holds its value until the next complete pair arrives.
- A new pair arriving while cmd_rdy=1 overwrites cmd; cmd_rdy stays 1.
- Transmitter FSM: IDLE -> START -> DATA (8 bits LSB first) -> STOP -> IDLE. Each state lasts BAUD_DIV clocks. resp is latched on send_resp.
- send_resp while tx_busy=1 is ignored; the frame in progress is not disturbed.
- RX and TX run fully independently; full duplex is allowed.

## Timing
- Reset values: TX=1, cmd=16'h0000, cmd_rdy=0, resp_sent=0, tx_busy=0; both RX FSMs in IDLE/WAIT_HIGH; all counters 0.
- rst mid-frame: returns to reset state on the next edge. A partial RX byte or partial pair is discarded. A TX frame is aborted and TX is driven high.
- Baud counter: 16 bits, counts 0..BAUD_DIV-1, then wraps. Bit index: 4 bits.
- cmd_rdy rises 1 clk after the low-byte stop-bit sample; cmd is valid on the same cycle.
- Receive latency, measured from the sync'd start-bit edge to cmd_rdy: one byte takes 9.5×BAUD_DIV + 1 clk. The pair latency is set by the initiator's inter-byte gap.
- clr_cmd_rdy and cmd_rdy set on the same cycle: set wins.
- TX drops low 1 clk after send_resp. tx_busy rises on that same cycle.
- Frame length is 10×BAUD_DIV clks. At the end of the stop bit, tx_busy falls and resp_sent rises on the same edge.
- resp_sent clears 1 clk after the next accepted send_resp.

## Test plan
- Reset, then send bytes 8'h02, 8'h00 (BAUD_DIV=16) -> cmd=16'h0200 and cmd_rdy=1 exactly 1 clk after the second stop sample. Pulse clr_cmd_rdy -> cmd_rdy=0 and cmd remains 16'h0200.
- send_resp with resp=8'hA5 -> TX low 1 clk later, bit pattern 0,1,0,1,0,0,1,0,1,1 at 16 clks/bit. resp_sent=1 and tx_busy=0 at clk 161. A second send_resp at clk 50 is ignored.
- Send 8'h4F, then idle more than 40 bit times, then send 8'h12, 8'h34 -> the first byte is dropped, cmd=16'h1234, and no cmd_rdy pulse occurs for 4F.
- Send a byte with its stop bit forced low, then 8'hAB, 8'hCD -> the framing error is discarded and cmd=16'hABCD.
- RX glitch low for 4 clks -> false start rejected; no byte is received.
- Assert rst mid-way through the second RX byte and mid-way through a TX frame -> TX=1, cmd_rdy=0, and tx_busy=0 on the next clk. A following clean pair 8'h10, 8'h02 yields cmd=16'h1002.

Source files
------------

// File: rtl/cmd_uart_responder.sv
// Responder end of the Bluetooth command link: assembles 16-bit commands from
// two 8N1 UART bytes (high byte first) and transmits 8-bit status responses.
//
// state     | meaning
// RX_IDLE   | waiting for a falling edge on the synchronised RX line
// RX_START  | half-bit wait, then re-check the start bit is still low
// RX_DATA   | sampling 8 data bits LSB first at mid-bit
// RX_STOP   | sampling the stop bit at mid-bit
// WAIT_HIGH | assembler expects the high command byte
// WAIT_LOW  | high byte held, low byte must start before the pair timeout
// TX_IDLE   | line idles high, waiting for send_resp
// TX_START  | driving the start bit
// TX_DATA   | driving 8 data bits LSB first
// TX_STOP   | driving the stop bit
module cmd_uart_responder #(
    parameter int BAUD_DIV     = 5208,
    parameter int PAIR_TIMEOUT = 40
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RX,
    output logic        TX,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        send_resp,
    output logic        resp_sent,
    output logic        tx_busy
);
    localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
    localparam logic [15:0] HALF_LAST = 16'(BAUD_DIV / 2 - 1);
    localparam int          TMO_CLKS  = PAIR_TIMEOUT * BAUD_DIV;
    localparam int          TMO_W     = $clog2(TMO_CLKS + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CLKS - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic       {WAIT_HIGH, WAIT_LOW} asm_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    rx_state_t        rx_state, rx_nxt;
    asm_state_t       asm_state, asm_nxt;
    tx_state_t        tx_state, tx_nxt;

    logic             rx_meta, rx_sync, rx_prev;
    logic [15:0]      rx_cnt;
    logic [3:0]       rx_idx;
    logic [7:0]       rx_shift;
    logic             rx_tick, rx_fall, byte_ok, byte_err;
    logic [7:0]       hi_byte;
    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_hit, hi_done, pair_done;
    logic [15:0]      tx_cnt;
    logic [3:0]       tx_idx;
    logic [7:0]       tx_data;
    logic             tx_tick;

    // ---------------- receiver ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= RX;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign rx_fall = rx_prev & ~rx_sync;
    assign rx_tick = (rx_state == RX_START) ? (rx_cnt == HALF_LAST) : (rx_cnt == BAUD_LAST);

    always_ff @(posedge clk) begin
        if (rst) rx_state <= RX_IDLE;
        else     rx_state <= rx_nxt;
    end

    always_comb begin
        rx_nxt = rx_state;
        case (rx_state)
            RX_IDLE:  if (rx_fall) rx_nxt = RX_START;
            RX_START: if (rx_tick) rx_nxt = rx_sync ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_tick && rx_idx == 4'd7) rx_nxt = RX_STOP;
            RX_STOP:  if (rx_tick) rx_nxt = RX_IDLE;
            default:  rx_nxt = RX_IDLE;
        endcase
    end

    always_comb begin
        byte_ok  = 1'b0;
        byte_err = 1'b0;
        if (rx_state == RX_STOP && rx_tick) begin
            byte_ok  = rx_sync;
            byte_err = ~rx_sync;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_shift <= '0;
        end else begin
            if (rx_state == RX_IDLE || rx_tick) rx_cnt <= '0;
            else                                rx_cnt <= rx_cnt + 16'd1;
            if (rx_state != RX_DATA) rx_idx <= '0;
            else if (rx_tick)        rx_idx <= rx_idx + 4'd1;
            if (rx_state == RX_DATA && rx_tick) rx_shift <= {rx_sync, rx_shift[7:1]};
        end
    end

    // ---------------- byte-pair assembler ----------------
    always_ff @(posedge clk) begin
        if (rst) asm_state <= WAIT_HIGH;
        else     asm_state <= asm_nxt;
    end

    assign tmo_hit = (asm_state == WAIT_LOW) && (tmo_cnt == TMO_LAST);

    always_comb begin
        asm_nxt = asm_state;
        case (asm_state)
            WAIT_HIGH: if (byte_ok) asm_nxt = WAIT_LOW;
            WAIT_LOW:  if (byte_ok || byte_err || tmo_hit) asm_nxt = WAIT_HIGH;
            default:   asm_nxt = WAIT_HIGH;
        endcase
    end

    always_comb begin
        hi_done   = (asm_state == WAIT_HIGH) && byte_ok;
        pair_done = (asm_state == WAIT_LOW) && byte_ok;
    end

    // Timeout only runs while the line is idle; a detected start bit restarts it.
    always_ff @(posedge clk) begin
        if (rst)
            tmo_cnt <= '0;
        else if (asm_state == WAIT_LOW && rx_state == RX_IDLE && !rx_fall && !tmo_hit)
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        else
            tmo_cnt <= '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_byte <= '0;
            cmd     <= '0;
            cmd_rdy <= 1'b0;
        end else begin
            if (hi_done)   hi_byte <= rx_shift;
            if (pair_done) cmd     <= {hi_byte, rx_shift};
            if (pair_done)                     cmd_rdy <= 1'b1;
            else if (clr_cmd_rdy || hi_done)   cmd_rdy <= 1'b0;
        end
    end

    // ---------------- transmitter ----------------
    assign tx_tick = (tx_cnt == BAUD_LAST);

    always_ff @(posedge clk) begin
        if (rst) tx_state <= TX_IDLE;
        else     tx_state <= tx_nxt;
    end

    always_comb begin
        tx_nxt = tx_state;
        case (tx_state)
            TX_IDLE:  if (send_resp) tx_nxt = TX_START;
            TX_START: if (tx_tick) tx_nxt = TX_DATA;
            TX_DATA:  if (tx_tick && tx_idx == 4'd7) tx_nxt = TX_STOP;
            TX_STOP:  if (tx_tick) tx_nxt = TX_IDLE;
            default:  tx_nxt = TX_IDLE;
        endcase
    end

    always_comb begin
        TX      = 1'b1;
        tx_busy = (tx_state != TX_IDLE);
        case (tx_state)
            TX_START: TX = 1'b0;
            TX_DATA:  TX = tx_data[tx_idx[2:0]];
            default:  TX = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_cnt    <= '0;
            tx_idx    <= '0;
            tx_data   <= '0;
            resp_sent <= 1'b0;
        end else begin
            if (tx_state == TX_IDLE || tx_tick) tx_cnt <= '0;
            else                                tx_cnt <= tx_cnt + 16'd1;
            if (tx_state != TX_DATA) tx_idx <= '0;
            else if (tx_tick)        tx_idx <= tx_idx + 4'd1;
            if (tx_state == TX_IDLE && send_resp) begin
                tx_data   <= resp;
                resp_sent <= 1'b0;
            end else if (tx_state == TX_STOP && tx_tick) begin
                resp_sent <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cmd_uart_responder.sv
// Self-checking bench for cmd_uart_responder: directed link scenarios plus
// randomized full-duplex traffic checked against a byte-level pairing model.
module tb_cmd_uart_responder;
    localparam int B  = 16;
    localparam int PT = 40;

    logic        clk = 1'b0, rst = 1'b1, RX = 1'b1;
    logic        clr_cmd_rdy = 1'b0, send_resp = 1'b0;
    logic [7:0]  resp = 8'h00;
    logic        TX, cmd_rdy, resp_sent, tx_busy;
    logic [15:0] cmd;

    int errors = 0, checks = 0, cyc = 0;
    int last_start = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cmd_uart_responder #(.BAUD_DIV(B), .PAIR_TIMEOUT(PT)) dut (
        .clk(clk), .rst(rst), .RX(RX), .TX(TX), .cmd(cmd), .cmd_rdy(cmd_rdy),
        .clr_cmd_rdy(clr_cmd_rdy), .resp(resp), .send_resp(send_resp),
        .resp_sent(resp_sent), .tx_busy(tx_busy)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic wait_clk(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // cmd_rdy rise monitor: records when it rose and what cmd held then
    int          rises = 0, rise_cyc = 0;
    logic [15:0] rise_cmd = 16'h0;
    logic        prev_rdy = 1'b0;
    always @(negedge clk) begin
        if (cmd_rdy && !prev_rdy) begin
            rises++;
            rise_cyc = cyc;
            rise_cmd = cmd;
        end
        prev_rdy = cmd_rdy;
    end

    // Reference model: byte-level pairing rules
    logic        m_hi_valid = 1'b0;
    logic [7:0]  m_hi = 8'h0;
    logic [15:0] m_cmd = 16'h0;
    logic        m_rdy = 1'b0;
    int          m_rises = 0;

    function automatic void model_reset();
        m_hi_valid = 1'b0;
        m_hi       = 8'h0;
        m_cmd      = 16'h0;
        m_rdy      = 1'b0;
    endfunction

    // gap_clks: idle line time between the previous stop bit end and this start bit
    function automatic void model_byte(input logic [7:0] b, input bit stop_ok, input int gap_clks);
        if (m_hi_valid && (B / 2 + gap_clks) >= PT * B) m_hi_valid = 1'b0;
        if (!stop_ok) begin
            m_hi_valid = 1'b0;
        end else if (!m_hi_valid) begin
            m_hi       = b;
            m_hi_valid = 1'b1;
            m_rdy      = 1'b0;
        end else begin
            m_cmd      = {m_hi, b};
            m_rdy      = 1'b1;
            m_hi_valid = 1'b0;
            m_rises++;
        end
    endfunction

    task automatic send_byte(input logic [7:0] b, input bit stop_ok, input int idle_bits);
        wait_clk(idle_bits * B);
        RX = 1'b0;
        last_start = cyc;
        wait_clk(B);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            wait_clk(B);
        end
        RX = stop_ok;
        wait_clk(B);
        RX = 1'b1;
        model_byte(b, stop_ok, idle_bits * B);
        check_val("cmd", 32'(cmd), 32'(m_cmd));
        check_val("cmd_rdy", 32'(cmd_rdy), 32'(m_rdy));
        check_val("rdy_rises", 32'(rises), 32'(m_rises));
    endtask

    task automatic pulse_clr();
        clr_cmd_rdy = 1'b1;
        wait_clk(1);
        clr_cmd_rdy = 1'b0;
        m_rdy = 1'b0;
        check_val("clr_rdy", 32'(cmd_rdy), 32'(m_rdy));
        check_val("clr_cmd_hold", 32'(cmd), 32'(m_cmd));
    endtask

    // One response frame; a second strobe with other data lands mid-frame
    task automatic tx_frame_check(input logic [7:0] r, input logic [7:0] other);
        logic [9:0] frame;
        frame = {1'b1, r, 1'b0};
        resp = r;
        send_resp = 1'b1;
        wait_clk(1);
        send_resp = 1'b0;
        resp = other;
        check_val("tx_start_low", 32'(TX), 32'(1'b0));
        check_val("tx_busy_rise", 32'(tx_busy), 32'(1'b1));
        check_val("resp_sent_clr", 32'(resp_sent), 32'(1'b0));
        for (int k = 1; k < 160; k++) begin
            wait_clk(1);
            if (k == 48) send_resp = 1'b1;
            if (k == 49) send_resp = 1'b0;
            if (k % 16 == 8) check_val("tx_bit", 32'(TX), 32'(frame[k / 16]));
        end
        check_val("tx_busy_end", 32'(tx_busy), 32'(1'b1));
        check_val("resp_sent_early", 32'(resp_sent), 32'(1'b0));
        wait_clk(1);
        check_val("tx_busy_fall", 32'(tx_busy), 32'(1'b0));
        check_val("resp_sent_set", 32'(resp_sent), 32'(1'b1));
        check_val("tx_idle_high", 32'(TX), 32'(1'b1));
    endtask

    task automatic rx_random();
        int next_idle;
        int kind;
        next_idle = 2;
        repeat (14) begin
            kind = $urandom_range(0, 3);
            case (kind)
                0: begin
                    send_byte(8'($urandom), 1'b1, next_idle);
                    send_byte(8'($urandom), 1'b1, $urandom_range(0, 20));
                    next_idle = $urandom_range(0, 3);
                end
                1: begin
                    send_byte(8'($urandom), 1'b1, next_idle);
                    next_idle = $urandom_range(45, 55);
                end
                2: begin
                    send_byte(8'($urandom), 1'b0, next_idle);
                    next_idle = $urandom_range(1, 3);
                end
                default: pulse_clr();
            endcase
        end
    endtask

    task automatic tx_random();
        repeat (4) begin
            wait_clk($urandom_range(1, 30));
            tx_frame_check(8'($urandom), 8'($urandom));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        wait_clk(3);
        check_val("rst_TX", 32'(TX), 32'(1'b1));
        check_val("rst_cmd", 32'(cmd), 32'h0);
        check_val("rst_cmd_rdy", 32'(cmd_rdy), 32'(1'b0));
        check_val("rst_resp_sent", 32'(resp_sent), 32'(1'b0));
        check_val("rst_tx_busy", 32'(tx_busy), 32'(1'b0));
        rst = 1'b0;
        model_reset();
        wait_clk(2);

        // basic pair and cmd_rdy latency from the low byte start
        send_byte(8'h02, 1'b1, 2);
        send_byte(8'h00, 1'b1, 0);
        check_val("rdy_latency", 32'(rise_cyc), 32'(last_start + 10 * B - B / 2 + 3));
        check_val("rise_cmd", 32'(rise_cmd), 32'h0200);
        pulse_clr();

        tx_frame_check(8'hA5, 8'h3C);

        // pair timeout drops the lone high byte
        send_byte(8'h4F, 1'b1, 1);
        send_byte(8'h12, 1'b1, 50);
        send_byte(8'h34, 1'b1, 3);

        // framing error discards the byte
        send_byte(8'h5A, 1'b0, 2);
        send_byte(8'hAB, 1'b1, 1);
        send_byte(8'hCD, 1'b1, 0);

        // short glitch must be rejected as a false start
        wait_clk(B);
        RX = 1'b0;
        wait_clk(4);
        RX = 1'b1;
        wait_clk(3 * B);
        check_val("glitch_rises", 32'(rises), 32'(m_rises));
        check_val("glitch_cmd", 32'(cmd), 32'(m_cmd));
        send_byte(8'h77, 1'b1, 0);
        send_byte(8'h88, 1'b1, 0);

        // reset mid low byte and mid TX frame
        send_byte(8'hE1, 1'b1, 2);
        resp = 8'h99;
        send_resp = 1'b1;
        wait_clk(1);
        send_resp = 1'b0;
        RX = 1'b0;
        wait_clk(B);
        RX = 1'b1;
        wait_clk(2 * B);
        RX = 1'b0;
        wait_clk(B);
        check_val("busy_pre_rst", 32'(tx_busy), 32'(1'b1));
        rst = 1'b1;
        RX = 1'b1;
        wait_clk(1);
        rst = 1'b0;
        check_val("mid_rst_TX", 32'(TX), 32'(1'b1));
        check_val("mid_rst_busy", 32'(tx_busy), 32'(1'b0));
        check_val("mid_rst_rdy", 32'(cmd_rdy), 32'(1'b0));
        check_val("mid_rst_cmd", 32'(cmd), 32'h0);
        check_val("mid_rst_sent", 32'(resp_sent), 32'(1'b0));
        model_reset();
        wait_clk(B);
        send_byte(8'h10, 1'b1, 0);
        send_byte(8'h02, 1'b1, 0);
        check_val("post_rst_cmd", 32'(cmd), 32'h1002);

        // randomized full-duplex traffic
        fork
            rx_random();
            tx_random();
        join

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
